pipe_seq_ctrl: RTL and testbench
================================

PIPE_SEQ_CTRL -- requirements
Module: pipe_seq_ctrl

Interface
REQ-001 SHALL provide parameter MEM_TIMEOUT, default 8: maximum MEM_WAIT cycles before ERROR.
REQ-002 SHALL provide parameter CNT_W, default 16: width of STALL_CNT.
REQ-003 CLK  input  1  rising-edge clock.
REQ-004 RST  input  1  reset, asynchronous, active-low.
REQ-005 START  input  1  begin pipeline fill from IDLE or HALTED.
REQ-006 HALT_REQ  input  1  request orderly drain.
REQ-007 MEM_REQ  input  1  instruction in MEM stage accesses data memory.
REQ-008 MEM_READY  input  1  data memory completes the access this cycle.
REQ-009 LOAD_USE  input  1  instruction in ID depends on a load in EX.
REQ-010 BRANCH_TAKEN  input  1  branch resolved taken in EX.
REQ-011 PC_WE, IFID_WE, IDEX_WE, EXMEM_WE, MEMWB_WE  output  1 each  stage-buffer write enables.
REQ-012 IFID_FLUSH, IDEX_FLUSH  output  1 each  load a bubble into the stage buffer.
REQ-013 BUF_RE  output  1  read enable to all stage buffers.
REQ-014 STATE  output  3  encoding: IDLE=0, FILL=1, RUN=2, MEM_WAIT=3, DRAIN=4, HALTED=5, ERROR=6.
REQ-015 ERR  output  1  high only in ERROR.
REQ-016 STALL_CNT  output  CNT_W  count of stall cycles.

Function
REQ-017 Outputs SHALL be decoded combinationally from the registered state, the registered counters and the current inputs; state and counters SHALL update on the rising edge of CLK.
REQ-018 Unlisted outputs SHALL be 0 in every state.
REQ-019 IDLE: all outputs 0; START=1 -> FILL with fill_cnt=0.
REQ-020 FILL: PC_WE=IFID_WE=BUF_RE=1; IDEX_WE=(fill_cnt>=1); EXMEM_WE=(fill_cnt>=2); MEMWB_WE=(fill_cnt>=3).
REQ-021 FILL: fill_cnt increments each cycle; after the fill_cnt=3 cycle -> RUN; FILL lasts exactly 4 cycles; FILL ignores the hazard inputs.
REQ-022 RUN: default all five WE=1 and BUF_RE=1.
REQ-023 RUN priority 1: MEM_REQ=1 and MEM_READY=0 -> all WE=0 this cycle, next state MEM_WAIT, wait_cnt=1.
REQ-024 RUN priority 2: BRANCH_TAKEN=1 -> IFID_FLUSH=IDEX_FLUSH=1 with all WE=1; LOAD_USE is ignored that cycle.
REQ-025 RUN priority 3: LOAD_USE=1 -> PC_WE=IFID_WE=0 and IDEX_FLUSH=1, other WE=1; remain in RUN.
REQ-026 RUN: HALT_REQ=1 with no MEM stall -> DRAIN with drain_cnt=0; branch or load-use actions of that cycle still apply.
REQ-027 MEM_WAIT: MEM_READY=0 -> all WE=0, BUF_RE=1, wait_cnt increments.
REQ-028 MEM_WAIT: MEM_READY=1 -> all WE=1 this cycle, return to RUN, wait_cnt cleared; HALT_REQ is ignored in MEM_WAIT.
REQ-029 MEM_WAIT: wait_cnt reaching MEM_TIMEOUT with MEM_READY=0 -> ERROR next cycle; MEM_READY=1 in that same cycle wins (return to RUN).
REQ-030 DRAIN: PC_WE=IFID_WE=0, IDEX_FLUSH=1, IDEX_WE=EXMEM_WE=MEMWB_WE=1, BUF_RE=1; drain_cnt increments; after drain_cnt=2 -> HALTED.
REQ-031 DRAIN: MEM_REQ=1 and MEM_READY=0 -> all WE=0, drain_cnt frozen, wait_cnt counts with the same timeout rule; MEM_READY clears wait_cnt.
REQ-032 HALTED: all WE=0, BUF_RE=1; START=1 -> FILL.
REQ-033 ERROR: all WE=0, BUF_RE=0, ERR=1; leave only via RST.
REQ-034 STALL_CNT SHALL increment on each cycle with PC_WE=0 in RUN or MEM_WAIT; it SHALL saturate at all-ones and never wrap.
REQ-035 START and HALT_REQ SHALL be ignored outside the states named above.

Reset
REQ-036 RST=0 SHALL immediately force STATE=IDLE and clear fill_cnt, wait_cnt, drain_cnt and STALL_CNT, regardless of CLK, including mid-FILL, MEM_WAIT or DRAIN.
REQ-037 During reset all outputs SHALL be 0.
REQ-038 The first rising edge after RST rises SHALL evaluate IDLE normally.

Verification
REQ-039 Reset, START pulse, 4 cycles -> MEMWB_WE first 1 on FILL cycle 4; STATE=2 on cycle 5.
REQ-040 RUN, MEM_REQ=1 with MEM_READY low 3 cycles then high -> WE low 3 cycles plus the entry cycle, all 1 on the ready cycle; STALL_CNT=4.
REQ-041 RUN, LOAD_USE and BRANCH_TAKEN both 1 -> PC_WE=1, IFID_FLUSH=IDEX_FLUSH=1, STALL_CNT unchanged.
REQ-042 MEM_READY held low, MEM_TIMEOUT=8 -> STATE=6 and ERR=1 after 8 MEM_WAIT cycles; START then ignored.
REQ-043 HALT_REQ in RUN -> 3 DRAIN cycles with PC_WE=0 and MEMWB_WE=1 -> STATE=5; START -> FILL.
REQ-044 RST asserted mid-MEM_WAIT, asynchronous to CLK -> outputs 0 and STATE=0 at once; STALL_CNT=0.

Source files
------------

// File: rtl/pipe_seq_ctrl.sv
// Pipeline sequencing controller: fills the pipeline, runs it with hazard
// handling (memory stalls, taken branches, load-use bubbles), drains it on
// request, and traps into ERROR when the data memory never answers.
module pipe_seq_ctrl #(
    parameter int MEM_TIMEOUT = 8,
    parameter int CNT_W       = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             HALT_REQ,
    input  logic             MEM_REQ,
    input  logic             MEM_READY,
    input  logic             LOAD_USE,
    input  logic             BRANCH_TAKEN,
    output logic             PC_WE,
    output logic             IFID_WE,
    output logic             IDEX_WE,
    output logic             EXMEM_WE,
    output logic             MEMWB_WE,
    output logic             IFID_FLUSH,
    output logic             IDEX_FLUSH,
    output logic             BUF_RE,
    output logic [2:0]       STATE,
    output logic             ERR,
    output logic [CNT_W-1:0] STALL_CNT
);

    // Memory handshake: MEM_REQ acts as "valid" for the access held in the
    // MEM stage and MEM_READY as "ready"; the access completes in the cycle
    // both are high. MEM_REQ high with MEM_READY low freezes every stage
    // buffer, and the stall is held until MEM_READY rises or the wait
    // counter reaches MEM_TIMEOUT.

    localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FILL     = 3'd1,
        S_RUN      = 3'd2,
        S_MEM_WAIT = 3'd3,
        S_DRAIN    = 3'd4,
        S_HALTED   = 3'd5,
        S_ERROR    = 3'd6
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        fill_cnt;
    logic [1:0]        fill_nxt;
    logic [1:0]        drain_cnt;
    logic [1:0]        drain_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_nxt;
    logic              mem_stall;
    logic              wait_expired;
    logic              stall_inc;

    assign mem_stall    = MEM_REQ && !MEM_READY;
    assign wait_expired = (wait_cnt >= WAIT_MAX);

    // Registered state doubles as the debug view of the FSM.
    assign STATE = state;

    // State and sequencing counters; reset clears everything immediately.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= S_IDLE;
            fill_cnt  <= 2'd0;
            drain_cnt <= 2'd0;
            wait_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            fill_cnt  <= fill_nxt;
            drain_cnt <= drain_nxt;
            wait_cnt  <= wait_nxt;
        end
    end

    // Next-state and output decode from registered state plus live inputs.
    always_comb begin
        state_nxt  = state;
        fill_nxt   = fill_cnt;
        drain_nxt  = drain_cnt;
        wait_nxt   = wait_cnt;
        PC_WE      = 1'b0;
        IFID_WE    = 1'b0;
        IDEX_WE    = 1'b0;
        EXMEM_WE   = 1'b0;
        MEMWB_WE   = 1'b0;
        IFID_FLUSH = 1'b0;
        IDEX_FLUSH = 1'b0;
        BUF_RE     = 1'b0;
        ERR        = 1'b0;

        case (state)
            S_IDLE: begin
                if (START) begin
                    state_nxt = S_FILL;
                    fill_nxt  = 2'd0;
                end
            end

            S_FILL: begin
                // Each fill cycle enables one more downstream stage.
                PC_WE    = 1'b1;
                IFID_WE  = 1'b1;
                BUF_RE   = 1'b1;
                IDEX_WE  = (fill_cnt >= 2'd1);
                EXMEM_WE = (fill_cnt >= 2'd2);
                MEMWB_WE = (fill_cnt == 2'd3);
                if (fill_cnt == 2'd3) begin
                    state_nxt = S_RUN;
                    fill_nxt  = 2'd0;
                end else begin
                    fill_nxt = fill_cnt + 2'd1;
                end
            end

            S_RUN: begin
                BUF_RE = 1'b1;
                if (mem_stall) begin
                    // Memory stall outranks everything, including HALT_REQ.
                    state_nxt = S_MEM_WAIT;
                    wait_nxt  = WAIT_W'(1);
                end else begin
                    PC_WE    = 1'b1;
                    IFID_WE  = 1'b1;
                    IDEX_WE  = 1'b1;
                    EXMEM_WE = 1'b1;
                    MEMWB_WE = 1'b1;
                    if (BRANCH_TAKEN) begin
                        // Squash the wrong-path instructions in IF/ID and ID/EX.
                        IFID_FLUSH = 1'b1;
                        IDEX_FLUSH = 1'b1;
                    end else if (LOAD_USE) begin
                        // Hold PC and IF/ID, insert a bubble behind the load.
                        PC_WE      = 1'b0;
                        IFID_WE    = 1'b0;
                        IDEX_FLUSH = 1'b1;
                    end
                    if (HALT_REQ) begin
                        state_nxt = S_DRAIN;
                        drain_nxt = 2'd0;
                    end
                end
            end

            S_MEM_WAIT: begin
                BUF_RE = 1'b1;
                if (MEM_READY) begin
                    PC_WE     = 1'b1;
                    IFID_WE   = 1'b1;
                    IDEX_WE   = 1'b1;
                    EXMEM_WE  = 1'b1;
                    MEMWB_WE  = 1'b1;
                    state_nxt = S_RUN;
                    wait_nxt  = '0;
                end else if (wait_expired) begin
                    state_nxt = S_ERROR;
                end else begin
                    wait_nxt = wait_cnt + WAIT_W'(1);
                end
            end

            S_DRAIN: begin
                // No new fetches; bubbles enter ID/EX while older work retires.
                BUF_RE     = 1'b1;
                IDEX_FLUSH = 1'b1;
                if (mem_stall) begin
                    if (wait_expired) begin
                        state_nxt = S_ERROR;
                    end else begin
                        wait_nxt = wait_cnt + WAIT_W'(1);
                    end
                end else begin
                    IDEX_WE  = 1'b1;
                    EXMEM_WE = 1'b1;
                    MEMWB_WE = 1'b1;
                    wait_nxt = '0;
                    if (drain_cnt == 2'd2) begin
                        state_nxt = S_HALTED;
                        drain_nxt = 2'd0;
                    end else begin
                        drain_nxt = drain_cnt + 2'd1;
                    end
                end
            end

            S_HALTED: begin
                BUF_RE = 1'b1;
                if (START) begin
                    state_nxt = S_FILL;
                    fill_nxt  = 2'd0;
                end
            end

            S_ERROR: begin
                ERR = 1'b1;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // A stall cycle is any RUN or MEM_WAIT cycle in which the PC is held.
    assign stall_inc = ((state == S_RUN) || (state == S_MEM_WAIT)) && !PC_WE;

    // Saturating stall counter.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            STALL_CNT <= '0;
        end else if (stall_inc && !(&STALL_CNT)) begin
            STALL_CNT <= STALL_CNT + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Bench for pipe_seq_ctrl: directed scenarios followed by random stimulus,
// all checked cycle by cycle against a behavioural model of the sequencer.
module tb_pipe_seq_ctrl;

  localparam int TO        = 8;
  localparam int CW        = 4;
  localparam int STALL_MAX = (1 << CW) - 1;

  localparam int M_IDLE = 0, M_FILL = 1, M_RUN = 2, M_WAIT = 3;
  localparam int M_DRAIN = 4, M_HALTED = 5, M_ERROR = 6;

  logic          CLK, RST;
  logic          START, HALT_REQ, MEM_REQ, MEM_READY, LOAD_USE, BRANCH_TAKEN;
  logic          PC_WE, IFID_WE, IDEX_WE, EXMEM_WE, MEMWB_WE;
  logic          IFID_FLUSH, IDEX_FLUSH, BUF_RE, ERR;
  logic [2:0]    STATE;
  logic [CW-1:0] STALL_CNT;

  pipe_seq_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST), .START(START), .HALT_REQ(HALT_REQ),
    .MEM_REQ(MEM_REQ), .MEM_READY(MEM_READY), .LOAD_USE(LOAD_USE),
    .BRANCH_TAKEN(BRANCH_TAKEN), .PC_WE(PC_WE), .IFID_WE(IFID_WE),
    .IDEX_WE(IDEX_WE), .EXMEM_WE(EXMEM_WE), .MEMWB_WE(MEMWB_WE),
    .IFID_FLUSH(IFID_FLUSH), .IDEX_FLUSH(IDEX_FLUSH), .BUF_RE(BUF_RE),
    .STATE(STATE), .ERR(ERR), .STALL_CNT(STALL_CNT)
  );

  // ---------------- clock / reset ----------------
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] obs_outs();
    return {23'd0, PC_WE, IFID_WE, IDEX_WE, EXMEM_WE, MEMWB_WE,
            IFID_FLUSH, IDEX_FLUSH, BUF_RE, ERR};
  endfunction

  // ---------------- reference model ----------------
  // Phase plus progress counters; "stalls" counts memory-stall cycles of the
  // current access (the cycle that raised it included).
  int m_phase, m_fill, m_drain, m_stalls, m_stall_cnt;

  task automatic model_reset();
    m_phase = M_IDLE; m_fill = 0; m_drain = 0; m_stalls = 0; m_stall_cnt = 0;
  endtask

  // Returns expected outputs {pc,ifid,idex,exmem,memwb,ifid_fl,idex_fl,re,err}
  // and the phase/counters after the clock edge.
  task automatic model_eval(input bit st, hr, mq, mr, lu, br,
                            output logic [8:0] eo, output int np, nf, nd, ns);
    bit pc, ifid, idex, exm, mwb, ffl, dfl, re, er;
    bit stall;
    {pc, ifid, idex, exm, mwb, ffl, dfl, re, er} = '0;
    np = m_phase; nf = m_fill; nd = m_drain; ns = m_stalls;
    stall = mq && !mr;
    case (m_phase)
      M_IDLE: if (st) begin np = M_FILL; nf = 0; end
      M_FILL: begin
        pc = 1; ifid = 1; re = 1;
        idex = (m_fill > 0); exm = (m_fill > 1); mwb = (m_fill > 2);
        nf = m_fill + 1;
        if (nf == 4) begin np = M_RUN; nf = 0; end
      end
      M_RUN: begin
        re = 1;
        if (stall) begin
          np = M_WAIT; ns = 1;
        end else begin
          {pc, ifid, idex, exm, mwb} = 5'b11111;
          if (br) begin ffl = 1; dfl = 1; end
          else if (lu) begin pc = 0; ifid = 0; dfl = 1; end
          if (hr) begin np = M_DRAIN; nd = 0; end
        end
      end
      M_WAIT: begin
        re = 1;
        if (mr) begin {pc, ifid, idex, exm, mwb} = 5'b11111; np = M_RUN; ns = 0; end
        else if (m_stalls == TO) np = M_ERROR;
        else ns = m_stalls + 1;
      end
      M_DRAIN: begin
        re = 1; dfl = 1;
        if (stall) begin
          if (m_stalls == TO) np = M_ERROR;
          else ns = m_stalls + 1;
        end else begin
          idex = 1; exm = 1; mwb = 1; ns = 0;
          nd = m_drain + 1;
          if (nd == 3) begin np = M_HALTED; nd = 0; end
        end
      end
      M_HALTED: begin
        re = 1;
        if (st) begin np = M_FILL; nf = 0; end
      end
      default: er = 1;
    endcase
    eo = {pc, ifid, idex, exm, mwb, ffl, dfl, re, er};
  endtask

  // ---------------- driver tasks ----------------
  // Called at posedge+1; drives inputs, checks at posedge+3, then clocks.
  task automatic drive_cycle(input bit st, hr, mq, mr, lu, br);
    logic [8:0] eo;
    int np, nf, nd, ns;
    START = st; HALT_REQ = hr; MEM_REQ = mq; MEM_READY = mr;
    LOAD_USE = lu; BRANCH_TAKEN = br;
    #2;
    model_eval(st, hr, mq, mr, lu, br, eo, np, nf, nd, ns);
    exp_q.push_back({23'd0, eo});
    exp_q.push_back(m_phase);
    exp_q.push_back(m_stall_cnt);
    check_eq("outs", obs_outs(), exp_q.pop_front());
    check_eq("state", 32'(STATE), exp_q.pop_front());
    check_eq("stall_cnt", 32'(STALL_CNT), exp_q.pop_front());
    @(posedge CLK);
    if ((m_phase == M_RUN || m_phase == M_WAIT) && !eo[8] && m_stall_cnt < STALL_MAX)
      m_stall_cnt++;
    m_phase = np; m_fill = nf; m_drain = nd; m_stalls = ns;
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) drive_cycle(0, 0, 0, 1, 0, 0);
  endtask

  // Asserts RST between clock edges and checks the immediate effect.
  task automatic async_reset();
    #2;
    RST = 1'b0;
    #1;
    check_eq("rst_outs", obs_outs(), 32'd0);
    check_eq("rst_state", 32'(STATE), 32'd0);
    check_eq("rst_stall", 32'(STALL_CNT), 32'd0);
    model_reset();
    @(posedge CLK);
    #1;
    check_eq("rst_hold_outs", obs_outs(), 32'd0);
    RST = 1'b1;
  endtask

  task automatic start_and_fill();
    drive_cycle(1, 0, 0, 1, 0, 0);
    idle_cycles(4);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    RST = 1'b0;
    START = 0; HALT_REQ = 0; MEM_REQ = 0; MEM_READY = 0; LOAD_USE = 0; BRANCH_TAKEN = 0;
    model_reset();
    #3;
    check_eq("reset_outs", obs_outs(), 32'd0);
    check_eq("reset_state", 32'(STATE), 32'd0);
    @(posedge CLK);
    #1;
    RST = 1'b1;

    // Pipeline fill: MEMWB_WE only on the fourth FILL cycle, then RUN.
    idle_cycles(2);
    drive_cycle(1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive_cycle(0, 0, 0, 1, 0, 0);
    end
    check_eq("fill_to_run", 32'(STATE), 32'd2);

    // Memory stall: entry cycle plus three waits, released by MEM_READY.
    for (int i = 0; i < 4; i++) drive_cycle(0, 0, 1, 0, 0, 0);
    drive_cycle(0, 0, 1, 1, 0, 0);
    check_eq("mem_stall_cnt", 32'(STALL_CNT), 32'd4);
    check_eq("mem_back_run", 32'(STATE), 32'd2);

    // Branch beats load-use: flush both, no stall counted.
    drive_cycle(0, 0, 0, 1, 1, 1);
    check_eq("br_lu_stall", 32'(STALL_CNT), 32'd4);
    drive_cycle(0, 0, 0, 1, 1, 0);
    check_eq("lu_stall", 32'(STALL_CNT), 32'd5);

    // Orderly drain: three DRAIN cycles, HALTED, restart.
    drive_cycle(0, 1, 0, 1, 0, 0);
    idle_cycles(3);
    check_eq("halted", 32'(STATE), 32'd5);
    start_and_fill();
    check_eq("restart_run", 32'(STATE), 32'd2);

    // Drain with a memory stall freezing progress.
    drive_cycle(0, 1, 0, 1, 0, 0);
    drive_cycle(0, 0, 1, 0, 0, 0);
    drive_cycle(0, 0, 1, 0, 0, 0);
    idle_cycles(3);
    check_eq("drain_stall_halted", 32'(STATE), 32'd5);
    start_and_fill();

    // Timeout boundary: ready arriving on the last permitted cycle wins.
    for (int i = 0; i < TO; i++) drive_cycle(0, 0, 1, 0, 0, 0);
    drive_cycle(0, 0, 1, 1, 0, 0);
    check_eq("timeout_edge_run", 32'(STATE), 32'd2);

    // Timeout: ready never comes; stall counter saturates on the way.
    for (int i = 0; i < TO + 1; i++) drive_cycle(0, 1, 1, 0, 0, 0);
    check_eq("timeout_err_state", 32'(STATE), 32'd6);
    check_eq("timeout_err_flag", 32'(ERR), 32'd1);
    check_eq("stall_saturated", 32'(STALL_CNT), 32'd15);
    for (int i = 0; i < 3; i++) drive_cycle(1, 0, 0, 1, 0, 0);
    check_eq("err_sticky", 32'(STATE), 32'd6);
    async_reset();

    // Reset landing in the middle of MEM_WAIT.
    start_and_fill();
    drive_cycle(0, 0, 1, 0, 0, 0);
    drive_cycle(0, 0, 1, 0, 0, 0);
    async_reset();

    // Random traffic, with ERROR recovery and occasional mid-cycle resets.
    for (int i = 0; i < 1500; i++) begin
      if (m_phase == M_ERROR || $urandom_range(0, 299) == 0) begin
        async_reset();
      end else begin
        drive_cycle($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
                    $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
